// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the 4-digit BCD display scanner: scan-state
// encoding and active-high 7-segment patterns (bit order g..a).
package bcd_disp_pkg;

    // One state per digit slot; the value doubles as the digit index.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } scan_state_t;

    localparam int NUM_DIGITS = 4;

    // Active-high segment patterns, bit 6 = g ... bit 0 = a.
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Anode pattern (active-low, one-hot-low) for a given scan state.
    function automatic logic [3:0] anode_pattern(input scan_state_t st);
        logic [3:0] an;
        an = 4'b1111;
        an[st] = 1'b0;
        return an;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to 7-segment decoder with blank override.
// Output is active-high, bit order g..a; non-BCD codes show a dash.
module seg7_decoder
    import bcd_disp_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    // Pattern lookup; blank forces every segment off.
    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (value)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd4_display_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A prescaler sets the slot length, a 4-state FSM walks the digits, and
// the digit values are snapshotted once per frame so a frame never mixes
// old and new digits. All pins are registered (1-cycle latency).
module bcd4_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int DIV = 1000
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic [3:0] d33_d30,
    input  logic [3:0] d23_d20,
    input  logic [3:0] d13_d10,
    input  logic [3:0] d03_d00,
    input  logic       ovf,
    input  logic       ovf_clr,
    input  logic       blank_en,
    output logic [3:0] an3_an0_,
    output logic [6:0] seg6_seg0_,
    output logic       dp_
);

    // Smallest width able to hold DIV-1.
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_reg;
    logic             tick;
    scan_state_t      state_reg;
    scan_state_t      state_next;
    logic [3:0]       snap_reg [NUM_DIGITS];
    logic [3:0]       digit_in [NUM_DIGITS];
    logic [NUM_DIGITS:0] zero_above;
    logic             ovf_flag_reg;
    logic             blank_sel;
    logic [6:0]       seg_active;
    logic [3:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;
    logic [3:0]       an_reg;
    logic [6:0]       seg_reg;
    logic             dp_reg;

    assign digit_in[0] = d03_d00;
    assign digit_in[1] = d13_d10;
    assign digit_in[2] = d23_d20;
    assign digit_in[3] = d33_d30;

    assign tick = (pre_reg == PRE_LAST);

    // Prescaler: counts 0..DIV-1 and wraps, producing one tick per slot.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            pre_reg <= '0;
        end else if (tick) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_reg + 1'b1;
        end
    end

    // Scan FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_reg <= S0;
        end else begin
            state_reg <= state_next;
        end
    end

    // Scan FSM next state: advance one digit per tick.
    always_comb begin
        state_next = state_reg;
        if (tick) begin
            case (state_reg)
                S0:      state_next = S1;
                S1:      state_next = S2;
                S2:      state_next = S3;
                S3:      state_next = S0;
                default: state_next = S0;
            endcase
        end
    end

    // Snapshot registers: reload only at the frame boundary (end of S3).
    // zero_above[k] is high when snapshot digits k..3 are all zero.
    assign zero_above[NUM_DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_snap
            always_ff @(posedge clock) begin
                if (!reset_) begin
                    snap_reg[gi] <= 4'd0;
                end else if (tick && (state_reg == S3)) begin
                    snap_reg[gi] <= digit_in[gi];
                end
            end
            assign zero_above[gi] = (snap_reg[gi] == 4'd0) && zero_above[gi+1];
        end
    endgenerate

    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            ovf_flag_reg <= 1'b0;
        end else if (ovf) begin
            ovf_flag_reg <= 1'b1;
        end else if (ovf_clr) begin
            ovf_flag_reg <= 1'b0;
        end
    end

    // Leading-zero blanking never applies to the units digit.
    assign blank_sel = blank_en && (state_reg != S0) && zero_above[state_reg];

    seg7_decoder u_dec (
        .value (snap_reg[state_reg]),
        .blank (blank_sel),
        .seg   (seg_active)
    );

    // Next pin values from the current state and snapshot.
    always_comb begin
        an_next  = anode_pattern(state_reg);
        seg_next = ~seg_active;
        dp_next  = ~((state_reg == S0) && ovf_flag_reg);
    end

    // Output registers: every pin changes one cycle after the state does.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            an_reg  <= 4'b1111;
            seg_reg <= 7'b1111111;
            dp_reg  <= 1'b1;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
        end
    end

    assign an3_an0_   = an_reg;
    assign seg6_seg0_ = seg_reg;
    assign dp_        = dp_reg;

endmodule

// File: tb/tb_bcd4_display_scanner.sv
// Self-checking bench for bcd4_display_scanner (DIV=4). Every clock the
// bench derives the expected pins from an edge-count model of the display,
// queues them, and compares once the DUT edge has happened.
module tb_bcd4_display_scanner;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic       clock = 1'b0;
    logic       reset_;
    logic [3:0] d33_d30, d23_d20, d13_d10, d03_d00;
    logic       ovf, ovf_clr, blank_en;
    logic [3:0] an3_an0_;
    logic [6:0] seg6_seg0_;
    logic       dp_;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [11:0] exp_q [$];
    string       tag_q [$];

    // Reference model state: edges since reset release, frame snapshot, flag.
    int         n_m;
    logic [3:0] snap_m [4];
    logic       flag_m;

    always #5 clock = ~clock;

    bcd4_display_scanner #(.DIV(DIV)) dut (
        .clock      (clock),
        .reset_     (reset_),
        .d33_d30    (d33_d30),
        .d23_d20    (d23_d20),
        .d13_d10    (d13_d10),
        .d03_d00    (d03_d00),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .blank_en   (blank_en),
        .an3_an0_   (an3_an0_),
        .seg6_seg0_ (seg6_seg0_),
        .dp_        (dp_)
    );

    task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: an/seg/dp got %b_%b_%b expected %b_%b_%b",
                     tag, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
        end else begin
            $display("[TB] ok   %s: an=%b seg=%b dp=%b", tag, got[11:8], got[7:1], got[0]);
        end
    endtask

    // Active-high g..a reference patterns.
    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // One clock: predict pins for the coming edge, queue, then compare.
    task automatic step(input string tag);
        logic [11:0] e;
        int          slot;
        logic        blank;
        logic [3:0]  one;
        if (!reset_) begin
            e      = {4'b1111, 7'b1111111, 1'b1};
            n_m    = 0;
            flag_m = 1'b0;
            for (int k = 0; k < 4; k++) snap_m[k] = 4'd0;
        end else begin
            slot  = (n_m / DIV) % 4;
            blank = blank_en && (slot != 0);
            for (int k = slot; k < 4; k++) if (snap_m[k] != 4'd0) blank = 1'b0;
            one      = 4'b0001 << slot;
            e[11:8]  = ~one;
            e[7:1]   = blank ? 7'b1111111 : ~ref_seg(snap_m[slot]);
            e[0]     = !((slot == 0) && flag_m);
            if ((n_m % FRAME) == FRAME - 1) begin
                snap_m[0] = d03_d00;
                snap_m[1] = d13_d10;
                snap_m[2] = d23_d20;
                snap_m[3] = d33_d30;
            end
            flag_m = ovf | (flag_m & ~ovf_clr);
            n_m++;
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        check_val(tag_q.pop_front(), {an3_an0_, seg6_seg0_, dp_}, exp_q.pop_front());
    endtask

    task automatic run(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) step(tag);
    endtask

    task automatic set_digits(input logic [15:0] v);
        {d33_d30, d23_d20, d13_d10, d03_d00} = v;
    endtask

    initial begin
        int s0_len;
        reset_   = 1'b0;
        ovf      = 1'b0;
        ovf_clr  = 1'b0;
        blank_en = 1'b0;
        set_digits(16'h1234);
        n_m      = 0;
        flag_m   = 1'b0;
        for (int k = 0; k < 4; k++) snap_m[k] = 4'd0;

        // Reset state, then first release edge shows '0' on digit 0.
        run("reset", 3);
        reset_ = 1'b1;
        step("release");
        check_val("release_const", {an3_an0_, seg6_seg0_, dp_}, {4'b1110, 7'b1000000, 1'b1});

        // Basic scan with 1,2,3,4 over several frames.
        run("scan1234", 39);
        // Now at the first edge of a frame: digit 0 shows '4'.
        while ((n_m % FRAME) != 0) step("align");
        step("frame_start");
        check_val("digit0_is_4", {an3_an0_, seg6_seg0_, dp_}, {4'b1110, 7'b0011001, 1'b1});

        // Leading-zero blanking.
        set_digits(16'h0007);
        blank_en = 1'b1;
        run("blank_on", 2 * FRAME);
        blank_en = 1'b0;
        run("blank_off", FRAME);

        // No tearing: change inputs at the start of S1.
        set_digits(16'h0000);
        run("zero", 2 * FRAME);
        while ((n_m % FRAME) != DIV) step("to_s1");
        set_digits(16'h0059);
        run("tear", 2 * FRAME);

        // Sticky overflow flag.
        ovf_clr = 1'b1;
        step("clr_only");
        ovf_clr = 1'b0;
        run("no_flag", FRAME);
        ovf = 1'b1;
        step("ovf_pulse");
        ovf = 1'b0;
        run("flag_set", FRAME + 2);
        ovf = 1'b1;
        ovf_clr = 1'b1;
        step("ovf_and_clr");
        ovf = 1'b0;
        ovf_clr = 1'b0;
        run("flag_kept", FRAME);
        ovf_clr = 1'b1;
        step("clr");
        ovf_clr = 1'b0;
        run("flag_gone", FRAME);

        // Non-BCD value shows a dash.
        set_digits(16'h0A00);
        run("dash", 2 * FRAME);

        // Reset in the middle of S2.
        set_digits(16'h1234);
        while ((n_m % FRAME) != 2 * DIV + 1) step("to_s2");
        reset_ = 1'b0;
        step("mid_reset");
        reset_ = 1'b1;
        s0_len = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            step("after_reset");
            if (an3_an0_ == 4'b1110 && s0_len == i) s0_len++;
        end
        tests_run++;
        if (s0_len != DIV) begin
            tests_failed++;
            $display("[TB] FAIL s0_len: got %0d cycles expected %0d", s0_len, DIV);
        end else begin
            $display("[TB] ok   s0_len: %0d cycles", s0_len);
        end
        run("post_reset", 2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
